ext_pipe: RTL and testbench

//   Parametrised, pipelined immediate-extension unit for the D/E boundary of the pipelined CPU.

---
 rtl/ext_pipe.sv | 116 +++++++++++
 tb/tb_ext_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// Pipelined immediate extender: widens IN_W -> OUT_W and carries the result through STAGES elastic stages.
// Optional byte modes (op 4/5) are compiled in when EXT_BYTE_MODES_EN is defined.
module ext_pipe #(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [3:0]       in_op,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic             out_err,
   output logic             busy
);

   localparam int PAD_W = OUT_W - IN_W;

   logic [OUT_W-1:0]  ext_imm;
   logic              ext_err;

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] err_q, err_d;
   logic [OUT_W-1:0]  imm_q [STAGES];
   logic [OUT_W-1:0]  imm_d [STAGES];
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] load;
   logic              in_xfer;

   always_comb begin
      ext_imm = '0;
      ext_err = 1'b0;
      case (in_op)
         4'd0: ext_imm = {{PAD_W{1'b0}}, in_imm};
         4'd1: ext_imm = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
         4'd2: ext_imm = {in_imm, {PAD_W{1'b0}}};
         // sign-extend then shift left by 2; the two top bits fall off
         4'd3: ext_imm = {{(PAD_W-2){in_imm[IN_W-1]}}, in_imm, 2'b00};
`ifdef EXT_BYTE_MODES_EN
         4'd4: ext_imm = {{(OUT_W-8){in_imm[7]}}, in_imm[7:0]};
         4'd5: ext_imm = {{(OUT_W-8){1'b0}}, in_imm[7:0]};
`endif
         default: ext_err = 1'b1;
      endcase
   end

   // A stage may advance when any later stage is empty or the sink is taking a beat.
   always_comb begin
      adv = '0;
      for (int i = 0; i < STAGES; i++) begin
         logic a;
         a = out_ready;
         for (int j = i + 1; j < STAGES; j++) begin
            a = a | ~v_q[j];
         end
         adv[i] = a;
      end
      load = ~v_q | adv;
   end

   assign in_ready = ~flush & load[0];
   assign in_xfer  = in_valid & in_ready;

   always_comb begin
      v_d   = v_q;
      err_d = err_q;
      imm_d = imm_q;
      if (load[0]) begin
         v_d[0] = in_xfer;
         if (in_xfer) begin
            imm_d[0] = ext_imm;
            err_d[0] = ext_err;
         end
      end
      // data only moves with a valid beat so the output register holds its last value
      for (int i = 1; i < STAGES; i++) begin
         if (load[i]) begin
            v_d[i] = v_q[i-1];
            if (v_q[i-1] & ~flush) begin
               imm_d[i] = imm_q[i-1];
               err_d[i] = err_q[i-1];
            end
         end
      end
      if (flush) begin
         v_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_q   <= '0;
         err_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            imm_q[i] <= '0;
         end
      end else begin
         v_q   <= v_d;
         err_q <= err_d;
         for (int i = 0; i < STAGES; i++) begin
            imm_q[i] <= imm_d[i];
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign out_imm   = imm_q[STAGES-1];
   assign out_err   = err_q[STAGES-1];
   assign busy      = |v_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed scenarios plus randomized traffic against a queue model.
module tb_ext_pipe;
   localparam int IN_W   = 16;
   localparam int OUT_W  = 32;
   localparam int STAGES = 2;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm = '0;
   logic [3:0]       in_op = '0;
   logic             flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_imm;
   logic             out_err;
   logic             busy;

   int checks = 0;
   int failures = 0;

   ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_imm(in_imm), .in_op(in_op), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_imm(out_imm), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Extension rules expressed as integer arithmetic modulo 2^OUT_W.
   function automatic longint ref_val(input int op, input longint imm);
      longint m, s, r, b;
      m = longint'(1) << OUT_W;
      s = (imm >= (longint'(1) << (IN_W-1))) ? imm - (longint'(1) << IN_W) : imm;
      case (op)
         0: r = imm;
         1: r = s;
         2: r = imm * (longint'(1) << (OUT_W-IN_W));
         3: r = s * 4;
`ifdef EXT_BYTE_MODES_EN
         4: begin b = imm % 256; r = (b >= 128) ? b - 256 : b; end
         5: r = imm % 256;
`endif
         default: r = 0;
      endcase
      return ((r % m) + m) % m;
   endfunction

   function automatic bit ref_err(input int op);
`ifdef EXT_BYTE_MODES_EN
      return op > 5;
`else
      return op > 3;
`endif
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_imm = '0; in_op = '0;
      repeat (2) tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (out_imm !== 32'h0) begin failures++; $display("FAIL reset_out_imm: got %h want 0", out_imm); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err: got %b want 0", out_err); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      out_ready = 1'b1; in_valid = 1'b1; in_imm = 16'h8000; in_op = 4'd1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early: out_valid got %b want 0 after 1 cycle", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid: out_valid got %b want 1 after 2 cycles", out_valid); end
      checks++; if (out_imm !== 32'hFFFF8000) begin failures++; $display("FAIL lat_imm: got %h want ffff8000", out_imm); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL lat_err: got %b want 0", out_err); end
      tick();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL lat_drain: out_valid=%b busy=%b want 0 0", out_valid, busy); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] b_imm [3];
      logic [3:0]  b_op  [3];
      logic [31:0] b_exp [3];
      b_imm = '{16'h8000, 16'h1234, 16'hFFFF};
      b_op  = '{4'd0, 4'd2, 4'd3};
      b_exp = '{32'h00008000, 32'h12340000, 32'hFFFFFFFC};
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c < 3) begin
            in_valid = 1'b1; in_imm = b_imm[c]; in_op = b_op[c];
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (c >= 1 && c <= 3) begin
            checks++;
            if (out_valid !== 1'b1 || out_imm !== b_exp[c-1]) begin
               failures++;
               $display("FAIL b2b_beat%0d: got valid=%b imm=%h want valid=1 imm=%h", c-1, out_valid, out_imm, b_exp[c-1]);
            end
         end
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end: out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_full();
      logic [15:0] f_imm [3];
      logic [3:0]  f_op  [3];
      longint      f_exp [3];
      int          got;
      f_imm = '{16'h0011, 16'h8001, 16'h00AB};
      f_op  = '{4'd0, 4'd1, 4'd2};
      for (int k = 0; k < 3; k++) f_exp[k] = ref_val(int'(f_op[k]), longint'(f_imm[k]));
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_imm = f_imm[k]; in_op = f_op[k];
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_accept%0d: in_ready got %b want 1", k, in_ready); end
         tick();
      end
      in_imm = f_imm[2]; in_op = f_op[2];
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_block: in_ready got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || longint'(out_imm) !== f_exp[0]) begin failures++; $display("FAIL full_head: valid=%b imm=%h want 1 %h", out_valid, out_imm, f_exp[0]); end
      tick();
      checks++; if (in_ready !== 1'b0 || longint'(out_imm) !== f_exp[0] || busy !== 1'b1) begin failures++; $display("FAIL full_hold: in_ready=%b imm=%h busy=%b want 0 %h 1", in_ready, out_imm, busy, f_exp[0]); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_release: in_ready got %b want 1", in_ready); end
      got = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid === 1'b1) begin
            if (got < 3) begin
               checks++;
               if (longint'(out_imm) !== f_exp[got]) begin failures++; $display("FAIL full_order%0d: got %h want %h", got, out_imm, f_exp[got]); end
            end
            got++;
         end
         tick();
         in_valid = 1'b0;
      end
      checks++; if (got !== 3) begin failures++; $display("FAIL full_count: got %0d beats want 3", got); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_idle: busy got %b want 0", busy); end
   endtask

   task automatic test_flush();
      int seen;
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_imm = 16'(k + 1); in_op = 4'd0;
         tick();
      end
      in_imm = 16'h0003; flush = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_clear: out_valid=%b busy=%b want 0 0", out_valid, busy); end
      out_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (out_valid === 1'b1) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL flush_leak: %0d beats emitted want 0", seen); end
   endtask

   task automatic test_illegal();
      logic [15:0] i_imm [4];
      logic [3:0]  i_op  [4];
      logic [31:0] i_exp [4];
      logic        i_err [4];
      i_imm = '{16'h1234, 16'h0080, 16'h00FF, 16'hBEEF};
      i_op  = '{4'd7, 4'd4, 4'd5, 4'd15};
`ifdef EXT_BYTE_MODES_EN
      i_exp = '{32'h0, 32'hFFFFFF80, 32'h000000FF, 32'h0};
      i_err = '{1'b1, 1'b0, 1'b0, 1'b1};
`else
      i_exp = '{32'h0, 32'h0, 32'h0, 32'h0};
      i_err = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_imm = i_imm[k]; in_op = i_op[k];
         tick();
         in_valid = 1'b0;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_imm !== i_exp[k] || out_err !== i_err[k]) begin
            failures++;
            $display("FAIL op%0d: got valid=%b imm=%h err=%b want 1 %h %b", i_op[k], out_valid, out_imm, out_err, i_exp[k], i_err[k]);
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_imm = 16'h1234; in_op = 4'd7;
      tick();
      in_imm = 16'h0042; in_op = 4'd0;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin failures++; $display("FAIL arst_pre: valid=%b err=%b want 1 1", out_valid, out_err); end
      #1 reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b want 0", busy); end
      checks++; if (out_err !== 1'b0 || out_imm !== 32'h0) begin failures++; $display("FAIL arst_data: err=%b imm=%h want 0 0", out_err, out_imm); end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      longint q_val [$];
      bit     q_err [$];
      bit     exp_ready, prev_stall;
      prev_stall = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_imm    = 16'($urandom);
         in_op     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         out_ready = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         #1;
         exp_ready = !flush && (q_val.size() < STAGES || out_ready);
         checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rnd_in_ready@%0d: got %b want %b", n, in_ready, exp_ready); end
         checks++; if (busy !== (q_val.size() > 0)) begin failures++; $display("FAIL rnd_busy@%0d: got %b want %b", n, busy, q_val.size() > 0); end
         if (q_val.size() == STAGES || prev_stall) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rnd_hold@%0d: out_valid got %b want 1", n, out_valid); end
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (q_val.size() == 0) begin
               failures++; $display("FAIL rnd_spurious@%0d: out_valid=1 with nothing in flight", n);
            end else if (longint'(out_imm) !== q_val[0] || out_err !== q_err[0]) begin
               failures++; $display("FAIL rnd_data@%0d: got imm=%h err=%b want %h %b", n, out_imm, out_err, q_val[0], q_err[0]);
            end
            if (out_ready && q_val.size() > 0) begin
               void'(q_val.pop_front()); void'(q_err.pop_front());
            end
         end
         prev_stall = (out_valid === 1'b1) && !out_ready && !flush;
         if (flush) begin
            q_val.delete(); q_err.delete();
         end else if (in_valid && exp_ready) begin
            q_val.push_back(ref_val(int'(in_op), longint'(in_imm)));
            q_err.push_back(ref_err(int'(in_op)));
         end
         tick();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (q_val.size() == 0) begin
               failures++; $display("FAIL drain_spurious: extra beat imm=%h", out_imm);
            end else begin
               if (longint'(out_imm) !== q_val[0] || out_err !== q_err[0]) begin
                  failures++; $display("FAIL drain_data: got imm=%h err=%b want %h %b", out_imm, out_err, q_val[0], q_err[0]);
               end
               void'(q_val.pop_front()); void'(q_err.pop_front());
            end
         end
         tick();
      end
      checks++; if (q_val.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL drain_lost: %0d beats missing busy=%b want 0 0", q_val.size(), busy); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_full();
      test_flush();
      test_illegal();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
